// File: rtl/exec_unit_if.sv
// ----------------------------------------------------------------------------
// exec_unit_if -- request/response bundle for exec_unit.
//
// Handshake rules:
//   A request transfers on a rising clk edge where in_valid and in_ready are
//   both 1. a, b and OpControl are only looked at on that edge. A response
//   transfers on a rising clk edge where out_valid and out_ready are both 1.
//   Result and Flags hold steady for as long as out_valid is 1.
//
// Signals:
//   in_valid / in_ready   request handshake
//   a, b                  operands (WIDTH bits)
//   OpControl             000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL,
//                         101-111 illegal
//   out_valid / out_ready response handshake
//   Result                registered result (WIDTH bits)
//   Flags                 registered {N,Z,C,V}
//
// Modports: master = requester/consumer side, slave = exec_unit side.
// ----------------------------------------------------------------------------
interface exec_unit_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       OpControl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic [3:0]       Flags;

   modport master (
      output in_valid, a, b, OpControl, out_ready,
      input  in_ready, out_valid, Result, Flags
   );

   modport slave (
      input  in_valid, a, b, OpControl, out_ready,
      output in_ready, out_valid, Result, Flags
   );
endinterface

// File: rtl/exec_unit.sv
// ----------------------------------------------------------------------------
// exec_unit -- single-issue ALU with an optional iterative multiplier.
//
// One request in flight at a time. ADD/SUB/AND/ORR and illegal opcodes are
// computed combinationally on acceptance and registered, so the response is
// presented the cycle after acceptance. MUL (when built in) runs a shift-add
// loop consuming one multiplier bit per cycle for WIDTH cycles.
//
// Optional feature macro: EXEC_UNIT_MUL_EN
//   defined   -> MUL state and shift-add datapath present
//   undefined -> no multiplier; OpControl 100 behaves as an illegal opcode
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high
//   bus        exec_unit_if.slave (request/response handshake, operands,
//              Result, Flags)
//   busy       1 whenever the FSM is not in IDLE
//   state_dbg  current FSM state (00 IDLE, 01 MUL, 10 DONE)
// ----------------------------------------------------------------------------
module exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   exec_unit_if.slave  bus,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_ORR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q,  flags_d;

   // Single-cycle ALU, evaluated on the live operands; only its value on the
   // accepting edge is ever captured.
   logic [WIDTH:0]   sum_add;
   logic [WIDTH:0]   sum_sub;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   always_comb begin
      sum_add = {1'b0, bus.a} + {1'b0, bus.b};
      sum_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (bus.OpControl)
         OP_ADD: begin
            alu_res = sum_add[WIDTH-1:0];
            alu_c   = sum_add[WIDTH];
            alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            // Carry out of a + ~b + 1 is the "no borrow" indication.
            alu_res = sum_sub[WIDTH-1:0];
            alu_c   = sum_sub[WIDTH];
            alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND:  alu_res = bus.a & bus.b;
         OP_ORR:  alu_res = bus.a | bus.b;
         // MUL is handled by the FSM when built in; otherwise it lands here
         // with the illegal opcodes: Result 0, which gives Flags 0100.
         default: alu_res = '0;
      endcase
   end

`ifdef EXEC_UNIT_MUL_EN
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_next;

   // Partial product for the current multiplier bit; only the low WIDTH
   // bits of the product are kept, so the shifted multiplicand may drop bits.
   always_comb begin
      acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   end
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
`ifdef EXEC_UNIT_MUL_EN
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
`ifdef EXEC_UNIT_MUL_EN
               if (bus.OpControl == OP_MUL) begin
                  state_d  = S_MUL;
                  cnt_d    = '0;
                  acc_d    = '0;
                  mcand_d  = bus.a;
                  mplier_d = bus.b;
               end else begin
                  state_d  = S_DONE;
                  result_d = alu_res;
                  flags_d  = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
               end
`else
               state_d  = S_DONE;
               result_d = alu_res;
               flags_d  = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
`endif
            end
         end
`ifdef EXEC_UNIT_MUL_EN
         S_MUL: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = S_DONE;
               cnt_d    = '0;
               result_d = acc_next;
               flags_d  = {acc_next[WIDTH-1], (acc_next == '0), 2'b00};
            end
         end
`endif
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         flags_q  <= '0;
`ifdef EXEC_UNIT_MUL_EN
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
`ifdef EXEC_UNIT_MUL_EN
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.Result    = result_q;
   assign bus.Flags     = flags_q;
   assign busy          = (state_q != S_IDLE);
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_exec_unit -- directed bench for exec_unit at WIDTH=32.
// Inputs change on the falling edge; outputs are sampled 1ns after the
// rising edge. Latency L means out_valid is seen L rising edges after the
// accepting edge is counted as edge 0, i.e. right after edge L-1.
// MUL vectors are compiled only when EXEC_UNIT_MUL_EN is defined.
// ----------------------------------------------------------------------------
module tb_exec_unit;

   localparam int W = 32;

   logic       clk;
   logic       reset;
   logic       busy;
   logic [1:0] state_dbg;

   exec_unit_if #(.WIDTH(W)) bus_if ();

   exec_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus_if),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Present a request and wait for out_valid; operands are scrambled right
   // after acceptance so any late sampling shows up in Result.
   task automatic issue(input string tag, input logic [2:0] op,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output bit busy_ok);
      @(negedge clk);
      check({tag, "_in_ready"}, 64'(bus_if.in_ready), 64'd1);
      bus_if.OpControl = op;
      bus_if.a         = av;
      bus_if.b         = bv;
      bus_if.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus_if.in_valid  = 1'b0;
      bus_if.a         = ~av;
      bus_if.b         = ~bv;
      bus_if.OpControl = 3'b001;
      lat     = 1;
      busy_ok = 1'b1;
      while (!bus_if.out_valid && lat < 200) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.out_ready = 1'b0;
      check({tag, "_post_out_valid"}, 64'(bus_if.out_valid), 64'd0);
      check({tag, "_post_in_ready"},  64'(bus_if.in_ready),  64'd1);
   endtask

   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int exp_lat, input logic [W-1:0] exp_res,
                         input logic [3:0] exp_flags);
      int lat;
      bit busy_ok;
      issue(tag, op, av, bv, lat, busy_ok);
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy"},    64'(busy_ok), 64'd1);
      check({tag, "_result"},  64'(bus_if.Result), 64'(exp_res));
      check({tag, "_flags"},   64'(bus_if.Flags), 64'(exp_flags));
      consume(tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int  lat;
      bit  busy_ok;
      bit  saw_valid;
      logic [W-1:0] held_res;
      logic [3:0]   held_flags;

      reset            = 1'b1;
      bus_if.in_valid  = 1'b1;   // must lose to reset
      bus_if.a         = 32'd9;
      bus_if.b         = 32'd9;
      bus_if.OpControl = 3'b000;
      bus_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  64'(bus_if.in_ready),  64'd1);
      check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      check("rst_busy",      64'(busy),             64'd0);
      check("rst_result",    64'(bus_if.Result),    64'd0);
      check("rst_flags",     64'(bus_if.Flags),     64'd0);
      check("rst_state",     64'(state_dbg),        64'd0);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      reset           = 1'b0;

      // out_ready while idle does nothing
      @(posedge clk);
      #1;
      check("idle_oready_state", 64'(state_dbg), 64'd0);
      @(negedge clk);
      bus_if.out_ready = 1'b0;

      // single-cycle ops
      run_op("add_ovf",   3'b000, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 4'b1001);
      run_op("add_carry", 3'b000, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000000, 4'b0110);
      run_op("sub_eq",    3'b001, 32'd5,        32'd5,        1, 32'h00000000, 4'b0110);
      run_op("sub_borrow",3'b001, 32'd0,        32'd1,        1, 32'hFFFFFFFF, 4'b1000);
      run_op("sub_ovf",   3'b001, 32'h80000000, 32'h00000001, 1, 32'h7FFFFFFF, 4'b0011);
      run_op("and",       3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 4'b1000);
      run_op("and_zero",  3'b010, 32'h0000000F, 32'h000000F0, 1, 32'h00000000, 4'b0100);
      run_op("orr",       3'b011, 32'h12340000, 32'h00005678, 1, 32'h12345678, 4'b0000);
      run_op("ill_111",   3'b111, 32'd3,        32'd4,        1, 32'h00000000, 4'b0100);
      run_op("ill_101",   3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 4'b0100);

`ifdef EXEC_UNIT_MUL_EN
      run_op("mul_small", 3'b100, 32'd3,        32'd4,        33, 32'd12,       4'b0000);
      run_op("mul_vec",   3'b100, 32'h0000FFFF, 32'h00010001, 33, 32'hFFFFFFFF, 4'b1000);
      run_op("mul_wrap",  3'b100, 32'h80000000, 32'h00000002, 33, 32'h00000000, 4'b0100);
`else
      run_op("op100_ill", 3'b100, 32'd3,        32'd4,        1, 32'h00000000, 4'b0100);
`endif

      // backpressure: hold DONE for 5 cycles with a competing request
      issue("bp", 3'b000, 32'd10, 32'd20, lat, busy_ok);
      check("bp_latency", 64'(lat), 64'd1);
      held_res   = bus_if.Result;
      held_flags = bus_if.Flags;
      check("bp_result", 64'(held_res), 64'd30);
      @(negedge clk);
      bus_if.in_valid  = 1'b1;
      bus_if.OpControl = 3'b011;
      bus_if.a         = 32'h00FF0000;
      bus_if.b         = 32'h000000FF;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_result", 64'(bus_if.Result),    64'd30);
         check("bp_hold_flags",  64'(bus_if.Flags),     64'd0);
         check("bp_in_ready",    64'(bus_if.in_ready),  64'd0);
         check("bp_out_valid",   64'(bus_if.out_valid), 64'd1);
      end
      @(negedge clk);
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hs_out_valid", 64'(bus_if.out_valid), 64'd0);
      check("bp_hs_in_ready",  64'(bus_if.in_ready),  64'd1);
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      @(posedge clk);            // pending request accepted here
      #1;
      bus_if.in_valid = 1'b0;
      check("bp_new_valid",  64'(bus_if.out_valid), 64'd1);
      check("bp_new_result", 64'(bus_if.Result),    64'h00FF00FF);
      check("bp_new_flags",  64'(bus_if.Flags),     64'd0);
      consume("bp_new");

      // reset while in DONE, with out_ready raised at the same edge
      issue("rst_done", 3'b000, 32'd1, 32'd1, lat, busy_ok);
      @(negedge clk);
      reset            = 1'b1;
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("rst_done_out_valid", 64'(bus_if.out_valid), 64'd0);
      check("rst_done_in_ready",  64'(bus_if.in_ready),  64'd1);
      check("rst_done_result",    64'(bus_if.Result),    64'd0);
      @(negedge clk);
      reset            = 1'b0;
      bus_if.out_ready = 1'b0;

`ifdef EXEC_UNIT_MUL_EN
      // reset 10 cycles into a MUL
      @(negedge clk);
      bus_if.OpControl = 3'b100;
      bus_if.a         = 32'h0000FFFF;
      bus_if.b         = 32'h00010001;
      bus_if.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("mid_mul_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_mul_state",     64'(state_dbg),        64'd0);
      check("mid_mul_out_valid", 64'(bus_if.out_valid), 64'd0);
      check("mid_mul_in_ready",  64'(bus_if.in_ready),  64'd1);
      @(negedge clk);
      reset     = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus_if.out_valid) saw_valid = 1'b1;
      end
      check("mid_mul_no_pulse", 64'(saw_valid), 64'd0);
`endif

      run_op("add_after_rst", 3'b000, 32'd2, 32'd3, 1, 32'd5, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result data width in bits (legal range 8..64).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  request valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-006 The block SHALL have ports a and b  input  WIDTH  operands, sampled only on acceptance.
REQ-007 The block SHALL have port OpControl  input  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101-111 illegal.
REQ-008 The block SHALL have port out_valid  output  1  Result/Flags valid.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 The block SHALL have port Result  output  WIDTH  registered result.
REQ-011 The block SHALL have port Flags  output  4  registered {N,Z,C,V}.
REQ-012 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-014 A request SHALL be accepted on a clk edge with in_valid=1 and in_ready=1; no overlap of requests (max one in flight).
REQ-015 ADD/SUB/AND/ORR/illegal SHALL go IDLE->DONE; out_valid asserts the cycle after acceptance (latency 1).
REQ-016 ADD: Result=a+b mod 2^WIDTH, C=carry out, V=signed overflow.
REQ-017 SUB: Result=a+~b+1, C=1 when no borrow (a>=b unsigned), V=signed overflow.
REQ-018 AND/ORR: bitwise result, C=0, V=0.
REQ-019 For all ops N=Result[WIDTH-1], Z=(Result==0).
REQ-020 Illegal op SHALL produce Result=0, Flags=4'b0100, latency 1.
REQ-021 MUL SHALL go IDLE->MUL, iterative shift-add: one multiplier bit per cycle, counter 0..WIDTH-1, then ->DONE; out_valid asserts WIDTH+1 cycles after acceptance.
REQ-022 MUL Result SHALL be the low WIDTH bits of the unsigned product; C=0, V=0.
REQ-023 In DONE, Result/Flags SHALL hold stable until out_ready=1; on that edge FSM returns to IDLE (next acceptance earliest one cycle later).
REQ-024 Input changes after acceptance (a, b, OpControl, in_valid) SHALL be ignored until IDLE.
REQ-025 out_ready while not in DONE SHALL have no effect.

Reset
REQ-026 On reset=1 at a clk edge: state IDLE, counter 0, Result 0, Flags 0, out_valid 0, busy 0, in_ready 1 next cycle.
REQ-027 Reset mid-MUL or in DONE SHALL discard the in-flight operation; no out_valid pulse results.
REQ-028 Reset SHALL take priority over simultaneous in_valid/out_ready.

Configuration
REQ-029 Macro EXEC_UNIT_MUL_EN defined: MUL state and iterative multiplier compiled in per REQ-021/022.
REQ-030 Macro EXEC_UNIT_MUL_EN undefined: no MUL state or datapath; OpControl 100 treated as illegal per REQ-020.

Verification (WIDTH=32)
REQ-031 ADD a=0x7FFFFFFF b=0x00000001 -> out_valid 1 cycle after accept, Result 0x80000000, Flags 1001.
REQ-032 SUB a=5 b=5 -> Result 0x00000000, Flags 0110; SUB a=0 b=1 -> Result 0xFFFFFFFF, Flags 1000.
REQ-033 MUL a=0x0000FFFF b=0x00010001 (macro on) -> out_valid exactly 33 cycles after accept, Result 0xFFFFFFFF, Flags 1000, busy high throughout.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE with new in_valid driven -> Result/Flags stable, in_ready=0, new request not accepted until one cycle after out_ready handshake.
REQ-035 Reset asserted 10 cycles into a MUL -> next cycle IDLE, out_valid=0, in_ready=1; following ADD 2+3 -> Result 5, Flags 0000.
REQ-036 Macro off: OpControl 100 with a=3 b=4 -> out_valid after 1 cycle, Result 0, Flags 0100; OpControl 111 same response in both builds.
